// File: rtl/muxn_pkg.sv
// Shared definitions for the N:1 pipelined selector: FSM state encodings, the
// beat record for the default configuration, and the select-width helper.
package muxn_pkg;

    localparam logic [1:0] MUXN_ST_EMPTY = 2'd0;
    localparam logic [1:0] MUXN_ST_ONE   = 2'd1;
    localparam logic [1:0] MUXN_ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = MUXN_ST_EMPTY,
        ST_ONE   = MUXN_ST_ONE,
        ST_TWO   = MUXN_ST_TWO
    } muxn_state_t;

    localparam int MUXN_WIDTH_DEF  = 32;
    localparam int MUXN_NUM_IN_DEF = 4;

    // Never narrower than one bit, so a 2:1 build still has a select line.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MUXN_WIDTH_DEF-1:0]         data;
        logic [sel_w(MUXN_NUM_IN_DEF)-1:0] sel;
        logic                              err;
    } muxn_beat_t;

endpackage

// File: rtl/muxn_select.sv
// Combinational N:1 selector; an index past the last input yields zero data
// with err raised.
module muxn_select
    import muxn_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_w(NUM_IN)
) (
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// N:1 datapath selector with a registered valid/ready output stage.
// Define MUXN_PIPE_SKID_EN to build the 2-entry skid version with a registered in_ready.
//
// state    | meaning
// ST_EMPTY | no beat held, out_valid=0
// ST_ONE   | beat in main register, presented downstream
// ST_TWO   | main presented, second beat parked in skid, in_ready=0
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } beat_t;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    beat_t            beat_in;
    beat_t            main_q;

    muxn_select #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_select (
        .in_sel  (in_sel),
        .in_data (in_data),
        .data    (sel_data),
        .err     (sel_err)
    );

    assign beat_in = '{data: sel_data, sel: in_sel, err: sel_err};

`ifdef MUXN_PIPE_SKID_EN
    muxn_state_t state_q, state_d;
    beat_t       skid_q, main_d, skid_d;

    // in_ready depends only on registered state: no path from out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_d  = beat_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_valid && out_ready) begin
                    main_d = beat_in;
                end else if (in_valid) begin
                    skid_d  = beat_in;
                    state_d = ST_TWO;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end
`else
    logic valid_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) main_q <= beat_in;
        end
    end
`endif

    assign out_data = main_q.data;
    assign out_sel  = main_q.sel;
    assign out_err  = main_q.err;

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: a 4-input and a 3-input instance share one
// beat stream; a reference model predicts each output and monitors compare.
module tb_muxn_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   in_sel = '0;
    logic [127:0] in_data = '0;

    logic         in_ready, a_ov, a_err;
    logic [31:0]  a_od;
    logic [1:0]   a_os;
    logic         b_in_ready, b_ov, b_err;
    logic [31:0]  b_od;
    logic [1:0]   b_os;

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(a_ov),
        .out_ready(out_ready), .out_data(a_od), .out_sel(a_os), .out_err(a_err)
    );

    muxn_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sel(in_sel), .in_data(in_data[95:0]), .out_valid(b_ov),
        .out_ready(out_ready), .out_data(b_od), .out_sel(b_os), .out_err(b_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc = 0;
    int   cyc = 0;
    bit   rnd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: input k of an n-input selector, or zero with err past the end.
    function automatic exp_t model(input int n, input logic [1:0] s, input logic [127:0] d);
        exp_t e;
        e.sel = s;
        if (int'(s) < n) begin
            e.data = d[int'(s)*32 +: 32];
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    exp_t held_a, held_b;
    bit   stall_a = 1'b0, stall_b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("hold_valid_a", 64'(a_ov), 64'(1));
                chk("hold_beat_a", 64'({a_od, a_os, a_err}), 64'(held_a));
            end
            if (a_ov && out_ready) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat_a got %0h want none", {a_od, a_os, a_err});
                end else begin
                    e = qa.pop_front();
                    pop_cyc.push_back(cyc);
                    chk("beat_a", 64'({a_od, a_os, a_err}), 64'(e));
                end
            end
            stall_a = a_ov && !out_ready;
            held_a  = '{a_od, a_os, a_err};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qb.delete();
            stall_b = 1'b0;
        end else begin
            if (stall_b) chk("hold_beat_b", 64'({b_ov, b_od, b_os, b_err}), 64'({1'b1, held_b}));
            if (b_ov && out_ready) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat_b got %0h want none", {b_od, b_os, b_err});
                end else begin
                    e = qb.pop_front();
                    chk("beat_b", 64'({b_od, b_os, b_err}), 64'(e));
                end
            end
            stall_b = b_ov && !out_ready;
            held_b  = '{b_od, b_os, b_err};
        end
    end

    task automatic rand_ready();
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Holds the beat until accepted; expectations are queued at acceptance.
    task automatic send_beat(input logic [1:0] s, input logic [127:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("ready_b", 64'(b_in_ready), 64'(1));
                qa.push_back(model(4, s, d));
                qb.push_back(model(3, s, d));
                n_acc++;
                @(posedge clk); #1;
                rand_ready();
                return;
            end
            if (t == 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout got in_ready=0 want 1 within 200 cycles");
            end
            @(posedge clk); #1;
            rand_ready();
        end
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = 2'($urandom);
        in_data  = rand128();
        @(posedge clk); #1;
        rand_ready();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_pending", 64'(qa.size() + qb.size()), 64'(0));
    endtask

    initial begin
        logic [127:0] d;
        int c0, p0, n0;

        // Reset with random inputs toggling.
        @(posedge clk); #1;
        repeat (2) begin
            in_valid  = 1'($urandom);
            in_sel    = 2'($urandom);
            in_data   = rand128();
            out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", 64'(a_ov), 64'(0));
            chk("rst_out_data", 64'(a_od), 64'(0));
            chk("rst_out_err", 64'(a_err), 64'(0));
            chk("rst_out_sel", 64'(a_os), 64'(0));
            @(posedge clk); #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Sweep: in_k = A000_000k, back-to-back.
        for (int j = 0; j < 4; j++) d[j*32 +: 32] = 32'hA000_0000 + 32'(j);
        c0 = cyc;
        p0 = pop_cyc.size();
        for (int k = 0; k < 4; k++) send_beat(2'(k), d);
        chk("sweep_in_cycles", 64'(cyc - c0), 64'(4));
        repeat (3) idle();
        chk("sweep_out_count", 64'(pop_cyc.size() - p0), 64'(4));
        if (pop_cyc.size() - p0 >= 4) begin
            chk("sweep_latency", 64'(pop_cyc[p0] - c0), 64'(1));
            chk("sweep_no_bubble", 64'(pop_cyc[p0+3] - pop_cyc[p0]), 64'(3));
        end

        // Out-of-range select on the 3-input instance.
        send_beat(2'd3, '1);
        send_beat(2'd2, rand128());
        drain();

        // Backpressure: 3 beats against 5 stalled cycles.
        n0 = n_acc;
        out_ready = 1'b0;
        fork
            begin
                send_beat(2'd1, rand128());
                send_beat(2'd2, rand128());
                send_beat(2'd3, rand128());
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
`ifdef MUXN_PIPE_SKID_EN
                chk("bp_held", 64'(n_acc - n0), 64'(2));
`else
                chk("bp_held", 64'(n_acc - n0), 64'(1));
`endif
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset while beats are held.
        out_ready = 1'b0;
        send_beat(2'd1, rand128());
`ifdef MUXN_PIPE_SKID_EN
        send_beat(2'd2, rand128());
`endif
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_valid", 64'(a_ov), 64'(1));
`ifdef MUXN_PIPE_SKID_EN
        chk("fill_full", 64'(in_ready), 64'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_flush_a", 64'(a_ov), 64'(0));
            chk("rst_flush_b", 64'(b_ov), 64'(0));
            @(posedge clk); #1;
        end
        send_beat(2'd0, rand128());
        drain();

        // Random valid/ready traffic.
        rnd = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_beat(2'($urandom), rand128());
        end
        rnd = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
